// File: rtl/control_sequencer.sv
// ============================================================================
// control_sequencer : five-step (T0..T4) microcode sequencer for an 8-bit CPU.
// Rev 1.0
// ============================================================================
`default_nettype none

module control_sequencer #(
   parameter int HALT_ON_UNDEF = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] opcode,
   input  logic       zf,
   input  logic       cf,
   output logic [2:0] step,
   output logic       zf_q,
   output logic       cf_q,
   output logic       hlt,
   output logic       mi,
   output logic       ri,
   output logic       ro,
   output logic       io,
   output logic       ii,
   output logic       ai,
   output logic       ao,
   output logic       eo,
   output logic       su,
   output logic       bi,
   output logic       oi,
   output logic       ce,
   output logic       co,
   output logic       j,
   output logic       fi
);

   localparam logic [2:0] c_t0 = 3'd0;
   localparam logic [2:0] c_t1 = 3'd1;
   localparam logic [2:0] c_t2 = 3'd2;
   localparam logic [2:0] c_t3 = 3'd3;
   localparam logic [2:0] c_t4 = 3'd4;

   logic [2:0] step_q;
   logic [2:0] step_d;
   logic       halted_q;
   logic       halted_d;
   logic       zf_d;
   logic       cf_d;
   logic       undef_op;
   logic       halt_op;

   assign step     = step_q;
   assign undef_op = (opcode >= 4'h9) && (opcode <= 4'hD);
   assign halt_op  = (opcode == 4'hF) || (undef_op && (HALT_ON_UNDEF != 0));

   always_comb begin
      hlt = 1'b0; mi = 1'b0; ri = 1'b0; ro = 1'b0;
      io  = 1'b0; ii = 1'b0; ai = 1'b0; ao = 1'b0;
      eo  = 1'b0; su = 1'b0; bi = 1'b0; oi = 1'b0;
      ce  = 1'b0; co = 1'b0; j  = 1'b0; fi = 1'b0;
      if (halted_q) begin
         hlt = 1'b1;
      end else begin
         case (step_q)
            c_t0: begin co = 1'b1; mi = 1'b1; end
            c_t1: begin ro = 1'b1; ii = 1'b1; ce = 1'b1; end
            c_t2: begin
               case (opcode)
                  4'h1, 4'h2, 4'h3, 4'h4: begin io = 1'b1; mi = 1'b1; end
                  4'h5: begin io = 1'b1; ai = 1'b1; end
                  4'h6: begin io = 1'b1; j = 1'b1; end
                  4'h7: begin io = cf_q; j = cf_q; end
                  4'h8: begin io = zf_q; j = zf_q; end
                  4'hE: begin ao = 1'b1; oi = 1'b1; end
                  default: hlt = halt_op;
               endcase
            end
            c_t3: begin
               case (opcode)
                  4'h1: begin ro = 1'b1; ai = 1'b1; end
                  4'h2: begin ro = 1'b1; bi = 1'b1; end
                  4'h3: begin ro = 1'b1; bi = 1'b1; su = 1'b1; end
                  4'h4: begin ao = 1'b1; ri = 1'b1; end
                  default: ;
               endcase
            end
            c_t4: begin
               if (opcode == 4'h2 || opcode == 4'h3) begin
                  eo = 1'b1; ai = 1'b1; fi = 1'b1;
                  su = (opcode == 4'h3);
               end
            end
            default: ;
         endcase
      end
   end

   // A halt freezes the counter at T2; only reset releases it.
   always_comb begin
      halted_d = halted_q | hlt;
      zf_d     = fi ? zf : zf_q;
      cf_d     = fi ? cf : cf_q;
      case (step_q)
         c_t0, c_t1, c_t2, c_t3: step_d = step_q + 3'd1;
         default:                step_d = c_t0;
      endcase
      if (halted_d) step_d = step_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         step_q   <= c_t0;
         halted_q <= 1'b0;
         zf_q     <= 1'b0;
         cf_q     <= 1'b0;
      end else begin
         step_q   <= step_d;
         halted_q <= halted_d;
         zf_q     <= zf_d;
         cf_q     <= cf_d;
      end
   end

endmodule

`default_nettype wire

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter: HALT_ON_UNDEF, default 0, meaning undefined opcodes act as HLT when 1 and as NOP when 0.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 opcode  input  4  instruction register upper nibble.
REQ-005 zf  input  1  ALU zero flag, combinational.
REQ-006 cf  input  1  ALU carry flag, combinational.
REQ-007 step  output  3  current T-state, 0..4.
REQ-008 zf_q / cf_q  output  1 each  latched flags.
REQ-009 Control outputs, 1 bit each, active-high:
- hlt: halt
- mi: MAR in
- ri: RAM in
- ro: RAM out
- io: IR operand out
- ii: IR in
- ai: A in
- ao: A out
- eo: ALU oe
- su: ALU sub
- bi: B in
- oi: OUT in
- ce: PC count enable
- co: PC out
- j: PC load
- fi: flags in

Function
REQ-010 The step counter SHALL advance 0->1->2->3->4->0 on each rising edge; 4 wraps to 0 with no skipping of idle steps.
REQ-011 Control outputs SHALL be a combinational decode of (step, opcode, zf_q, cf_q); every output not listed for a step is 0.
REQ-012 Fetch, for all opcodes:
- T0: co, mi
- T1: ro, ii, ce
REQ-013 0x0 NOP: T2-T4 all outputs 0.
REQ-014 0x1 LDA:
- T2: io, mi
- T3: ro, ai
REQ-015 0x2 ADD:
- T2: io, mi
- T3: ro, bi
- T4: eo, ai, fi
REQ-016 0x3 SUB: same as ADD, with su additionally high in T3 and T4.
REQ-017 0x4 STA:
- T2: io, mi
- T3: ao, ri
REQ-018 0x5 LDI: T2: io, ai.
REQ-019 0x6 JMP: T2: io, j.
REQ-020 0x7 JC: T2: io, j only when cf_q=1; otherwise all outputs 0.
REQ-021 0x8 JZ: T2: io, j only when zf_q=1; otherwise all outputs 0.
REQ-022 0xE OUT: T2: ao, oi.
REQ-023 0xF HLT: in T2, hlt SHALL be 1 and step SHALL freeze at 2 until reset; all other outputs 0.
REQ-024 Opcodes 0x9-0xD:
- HALT_ON_UNDEF=0: decode as NOP.
- HALT_ON_UNDEF=1: decode as HLT.
REQ-025 Flags:
- On a rising edge with fi=1: zf_q<=zf and cf_q<=cf.
- Otherwise zf_q and cf_q hold.
REQ-026 Flags latched at the T4 edge of an ADD/SUB SHALL be visible to a JC/JZ at that instruction's T2 with no extra delay.
REQ-027 opcode SHALL be sampled combinationally each step; a change in opcode during T0/T1 SHALL have no effect on fetch outputs.
REQ-028 su SHALL never be high outside SUB T3/T4.
REQ-029 eo and ao SHALL never be high in the same step.

Reset
REQ-030 rst=0 SHALL immediately force step=0, zf_q=0, cf_q=0 and clear the halt state, independent of clk.
REQ-031 While rst=0, outputs SHALL reflect T0 decode (co=1, mi=1, all others 0).
REQ-032 Deassertion of rst SHALL take effect at the first rising edge after release, which advances step 0->1.
REQ-033 Reset asserted mid-instruction, including during HLT, SHALL abort the instruction with no flag update.

Verification
REQ-034 Fetch/ADD: opcode=0x2, zf=0, cf=1, five edges after reset -> step sequence 0,1,2,3,4 with outputs per REQ-012/015; zf_q=0, cf_q=1 after the T4 edge; step=0 after the fifth edge.
REQ-035 SUB then JZ:
- SUB with zf=1, cf=0 -> zf_q=1 after T4.
- Next instruction opcode=0x8 -> T2 shows io=1, j=1.
- Repeat with zf_q=0 -> T2 all outputs 0.
REQ-036 HLT: opcode=0xF -> step freezes at 2 with hlt=1 for 10+ edges; assert rst=0 mid-cycle -> step=0, hlt=0 asynchronously.
REQ-037 Undefined opcode 0xA:
- HALT_ON_UNDEF=0 -> T2-T4 all outputs 0 and step wraps to 0.
- HALT_ON_UNDEF=1 -> step freezes at 2 with hlt=1.
REQ-038 Async reset: with zf_q=1 and cf_q=1, assert rst=0 between edges at step 3 -> zf_q=0, cf_q=0, step=0 with no clk edge.
REQ-039 Exhaustive sweep: all 16 opcodes × 5 steps × 4 flag combinations -> decode matches REQ-012..024; eo and ao never high together; su high only in SUB T3/T4.
